// File: rtl/display_ctrl.sv
// -----------------------------------------------------------------------------
// calc_pkg  : shared calculator number type (BCD significand + exponent).
// display_ctrl : display sequencer in front of screen_driver.
//
// Chooses the number shown on the display (idle zero, operand being typed,
// computed result, or the held value while in error), drives the shift
// override controls of screen_driver, generates the digit-refresh enable for
// the multiplexed scan and a blink/blank signal used to flash the display in
// the error state.
//
// Ports:
//   clk_i                    clock
//   rst_i                    synchronous active-high reset
//   entry_valid_i            pulse: new operand on entry_num_i / entry_shift_i
//   entry_num_i              operand being typed
//   entry_shift_i            fixed shift amount for operand display
//   result_valid_i           pulse: result_num_i valid
//   result_num_i             computed result
//   error_i                  pulse: arithmetic error / overflow
//   clear_i                  pulse: clear display
//   num_o                    number for screen_driver
//   override_shift_amount_o  shift override enable for screen_driver
//   new_shift_amount_o       shift amount used while override is active
//   refresh_en_o             one-cycle digit-advance enable
//   blank_o                  1 = all anodes off
//   state_o                  IDLE=0, ENTRY=1, RESULT=2, ERROR=3
// All outputs are registered; an accepted event shows up one cycle later.
// -----------------------------------------------------------------------------
package calc_pkg;
    localparam int NumDigits = 4;

    typedef struct packed {
        logic [NumDigits-1:0][3:0] digits;
        logic [2:0]                exponent;
    } num_t;
endpackage

module display_ctrl #(
    parameter int RefreshDiv      = 1000,
    parameter int BlinkCycles     = 12_500_000,
    parameter int ErrorHoldCycles = 100_000_000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                entry_valid_i,
    input  calc_pkg::num_t      entry_num_i,
    input  logic [2:0]          entry_shift_i,
    input  logic                result_valid_i,
    input  calc_pkg::num_t      result_num_i,
    input  logic                error_i,
    input  logic                clear_i,
    output calc_pkg::num_t      num_o,
    output logic                override_shift_amount_o,
    output logic [2:0]          new_shift_amount_o,
    output logic                refresh_en_o,
    output logic                blank_o,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_RESULT = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    localparam int RefW   = (RefreshDiv > 1)      ? $clog2(RefreshDiv)      : 1;
    localparam int BlinkW = (BlinkCycles > 1)     ? $clog2(BlinkCycles)     : 1;
    localparam int HoldW  = (ErrorHoldCycles > 1) ? $clog2(ErrorHoldCycles) : 1;

    localparam logic [RefW-1:0]   REF_LAST   = RefW'(RefreshDiv - 1);
    localparam logic [BlinkW-1:0] BLINK_LAST = BlinkW'(BlinkCycles - 1);
    // With ErrorHoldCycles == 0 the hold counter never advances and the
    // timeout compare is disabled, so this value is unused in that case.
    localparam logic [HoldW-1:0]  HOLD_LAST  =
        HoldW'((ErrorHoldCycles > 0) ? ErrorHoldCycles - 1 : 0);
    localparam bit HOLD_EN = (ErrorHoldCycles != 0);

    state_t              state_reg;
    calc_pkg::num_t      num_reg;
    logic                override_reg;
    logic [2:0]          shift_reg;
    logic                refresh_reg;
    logic                blank_reg;
    logic [RefW-1:0]     ref_cnt_reg;
    logic [BlinkW-1:0]   blink_cnt_reg;
    logic [HoldW-1:0]    hold_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            num_reg       <= '0;
            override_reg  <= 1'b0;
            shift_reg     <= 3'd0;
            refresh_reg   <= 1'b0;
            blank_reg     <= 1'b0;
            ref_cnt_reg   <= '0;
            blink_cnt_reg <= '0;
            hold_cnt_reg  <= '0;
        end else begin
            // Free-running scan prescaler, independent of the display state.
            ref_cnt_reg <= (ref_cnt_reg == REF_LAST) ? '0 : ref_cnt_reg + RefW'(1);
            refresh_reg <= (ref_cnt_reg == REF_LAST);

            if (clear_i) begin
                state_reg     <= ST_IDLE;
                num_reg       <= '0;
                override_reg  <= 1'b0;
                shift_reg     <= 3'd0;
                blank_reg     <= 1'b0;
                blink_cnt_reg <= '0;
                hold_cnt_reg  <= '0;
            end else if (error_i) begin
                // Also taken while already in ERROR: restarts both timers.
                state_reg     <= ST_ERROR;
                override_reg  <= 1'b0;
                shift_reg     <= 3'd0;
                blank_reg     <= 1'b0;
                blink_cnt_reg <= '0;
                hold_cnt_reg  <= '0;
            end else if (state_reg == ST_ERROR) begin
                // Operand and result events are dropped while in ERROR.
                if (HOLD_EN && hold_cnt_reg == HOLD_LAST) begin
                    state_reg     <= ST_IDLE;
                    num_reg       <= '0;
                    blank_reg     <= 1'b0;
                    blink_cnt_reg <= '0;
                    hold_cnt_reg  <= '0;
                end else begin
                    if (HOLD_EN) begin
                        hold_cnt_reg <= hold_cnt_reg + HoldW'(1);
                    end
                    if (blink_cnt_reg == BLINK_LAST) begin
                        blink_cnt_reg <= '0;
                        blank_reg     <= ~blank_reg;
                    end else begin
                        blink_cnt_reg <= blink_cnt_reg + BlinkW'(1);
                    end
                end
            end else if (result_valid_i) begin
                state_reg    <= ST_RESULT;
                num_reg      <= result_num_i;
                override_reg <= 1'b0;
                shift_reg    <= 3'd0;
                blank_reg    <= 1'b0;
            end else if (entry_valid_i) begin
                state_reg    <= ST_ENTRY;
                num_reg      <= entry_num_i;
                override_reg <= 1'b1;
                shift_reg    <= entry_shift_i;
                blank_reg    <= 1'b0;
            end
        end
    end

    assign num_o                   = num_reg;
    assign override_shift_amount_o = override_reg;
    assign new_shift_amount_o      = shift_reg;
    assign refresh_en_o            = refresh_reg;
    assign blank_o                 = blank_reg;
    assign state_o                 = state_reg;

endmodule

// File: doc/display_ctrl.md
Name: display_ctrl

Overview:
Sequencer in front of screen_driver. Selects which number the display shows (idle zero, operand being entered, computed result, error), and drives the shift-override controls. Generates the digit-refresh enable that paces the multiplexing scan, and produces a blink/blank signal for error indication. Sits between the calculator core and screen_driver; the top level gates anodes with blank_o.

Parameters:
RefreshDiv, 1000, clock cycles per refresh_en_o pulse (>=2)
BlinkCycles, 12_500_000, cycles between blank_o toggles in ERROR (>=1)
ErrorHoldCycles, 100_000_000, cycles ERROR is held before auto-return to IDLE; 0 = hold until clear_i

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
entry_valid_i  input  1  pulse: new operand value on entry_num_i/entry_shift_i
entry_num_i  input  calc_pkg::num_t  operand being typed
entry_shift_i  input  3  fixed shift amount for operand display
result_valid_i  input  1  pulse: result_num_i valid
result_num_i  input  calc_pkg::num_t  computed result
error_i  input  1  pulse: arithmetic error/overflow
clear_i  input  1  pulse: clear display
num_o  output  calc_pkg::num_t  number for screen_driver num_i
override_shift_amount_o  output  1  to screen_driver override_shift_amount_i
new_shift_amount_o  output  3  to screen_driver new_shift_amount_i
refresh_en_o  output  1  one-cycle digit-advance enable for the scan
blank_o  output  1  1 = all anodes off
state_o  output  2  current state (IDLE=0, ENTRY=1, RESULT=2, ERROR=3)

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high.
- Registered outputs: all outputs are registered. An accepted event is visible on the outputs on the cycle after it is sampled (1-cycle latency).
- Reset values: state IDLE; num_o all-zero (every significand digit 0, exponent 0); override_shift_amount_o 0; new_shift_amount_o 0; refresh_en_o 0; blank_o 0; all counters 0.
- Reset mid-operation: any state and any counter value returns to the reset values on the next edge, regardless of other inputs.
- Refresh prescaler: free-running counter 0..RefreshDiv-1 that wraps to 0. refresh_en_o=1 for exactly one cycle when the counter equals RefreshDiv-1, giving period RefreshDiv. It runs in all states and is unaffected by events.
- Event priority in a single cycle: clear_i > error_i > result_valid_i > entry_valid_i. Only the highest-priority event is acted on; the others are dropped.
- clear_i: go to IDLE from any state. num_o=0, override=0, blank_o=0.
- error_i: go to ERROR from any state, including ERROR itself, which restarts the error timers.
  - num_o keeps its prior value.
  - Blink and hold counters clear to 0.
  - blank_o=0 on the first ERROR cycle, then toggles every BlinkCycles cycles.
  - override_shift_amount_o=0.
- result_valid_i: latch result_num_i into num_o and go to RESULT. Accepted in IDLE, ENTRY and RESULT; ignored in ERROR. override=0, blank_o=0.
- entry_valid_i: latch entry_num_i into num_o and entry_shift_i into new_shift_amount_o, then go to ENTRY. Accepted in IDLE, ENTRY and RESULT; ignored in ERROR.
  - In ENTRY: override_shift_amount_o=1, blank_o=0.
  - In every other state: new_shift_amount_o=0 and override=0.
- ERROR exit: if ErrorHoldCycles!=0, after ErrorHoldCycles cycles in ERROR the block enters IDLE with num_o=0 and blank_o=0. Otherwise ERROR is left only via clear_i or reset.
- ERROR re-entry: error_i on the same cycle the hold expires wins; the block stays in ERROR with counters cleared.
- Counter widths: blink and hold counters are sized with $clog2 of their parameter (min 1 bit) and never wrap silently; each compares to its parameter minus 1.
- Outside ERROR: blank_o is held at 0.

Test Plan:
(All scenarios use RefreshDiv=4, BlinkCycles=3, ErrorHoldCycles=10.)
1. Reset:
   - Stimulus: assert rst_i 2 cycles, release, idle 12 cycles.
   - Required: state_o=0, num_o=0, blank_o=0; refresh_en_o high on cycles 4, 8, 12 after release only.
2. Entry then result:
   - Stimulus: entry_valid_i with digits 1,2,3 and entry_shift_i=2; then result_valid_i with value 5.
   - Required after entry: next cycle num_o=entry value, override=1, new_shift=2, state_o=1.
   - Required after result: num_o=5, override=0, new_shift=0, state_o=2.
3. Simultaneous events:
   - Stimulus: error_i+result_valid_i same cycle (state RESULT, num_o=5).
   - Required: state_o=3, num_o stays 5.
   - Stimulus: then clear_i+error_i same cycle.
   - Required: state_o=0, num_o=0.
4. Error blink and timeout:
   - Stimulus: error_i in IDLE.
   - Required: blank_o=0 for 3 cycles, 1 for 3, 0 for 3, then 1; auto-return to IDLE after 10 ERROR cycles with blank_o=0.
   - Stimulus: entry_valid_i during ERROR.
   - Required: ignored (num_o unchanged).
5. Error restart:
   - Stimulus: error_i again at ERROR cycle 9.
   - Required: hold restarts; IDLE reached 10 cycles after the second pulse. blank_o restarts at 0.
6. Reset mid-ERROR with blank_o=1:
   - Required: next cycle all outputs at reset values; prescaler restarts, so refresh_en_o first pulses 4 cycles after release.
